// File: rtl/aurora_tx_framer_pkg.sv
// Shared constants and types for the Aurora TX line framer and its FIFO.
// Holds the header layout, the line index width and the framer state encoding.
package aurora_tx_framer_pkg;

    localparam logic [15:0] HDR_MAGIC  = 16'hA55A;
    localparam int          LINE_IDX_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TAIL    = 2'd3
    } state_t;

    function automatic logic [31:0] make_hdr(input logic first_line,
                                             input logic [LINE_IDX_W-1:0] line_idx);
        return {HDR_MAGIC, first_line, 3'b000, line_idx};
    endfunction

endpackage

// File: rtl/aurora_tx_framer_if.sv
// AXI-Stream link from the framer to the Aurora TX core.
// The framer drives data/valid/last/keep and the Aurora core returns tready.
interface aurora_tx_framer_if;
    logic [31:0] m_axi_tx_tdata;
    logic [3:0]  m_axi_tx_tkeep;
    logic        m_axi_tx_tlast;
    logic        m_axi_tx_tvalid;
    logic        m_axi_tx_tready;

    modport master (
        output m_axi_tx_tdata,
        output m_axi_tx_tkeep,
        output m_axi_tx_tlast,
        output m_axi_tx_tvalid,
        input  m_axi_tx_tready
    );

    modport slave (
        input  m_axi_tx_tdata,
        input  m_axi_tx_tkeep,
        input  m_axi_tx_tlast,
        input  m_axi_tx_tvalid,
        output m_axi_tx_tready
    );
endinterface

// File: rtl/aurora_tx_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
// Zero-latency read data; writes while full and reads while empty are ignored.
module aurora_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_full,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_count   = wr_ptr_q - rd_ptr_q;
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_fire = i_wr_en & ~o_full & ~i_flush;
    assign rd_fire = i_rd_en & ~o_empty & ~i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/aurora_tx_framer.sv
// Buffers camera pixel words and frames each line as HEAD, LINE_WORDS payload beats, checksum TAIL.
// tvalid follows the FSM state by one cycle; tready stalls hold the beat, a full buffer drops input words.
module aurora_tx_framer
    import aurora_tx_framer_pkg::*;
#(
    parameter int LINE_WORDS = 480,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic [31:0]        i_pix_data,
    input  logic               i_pix_valid,
    output logic               o_pix_ready,
    input  logic               i_channel_up,
    aurora_tx_framer_if.master tx,
    output logic               o_overflow,
    output logic               o_pkt_abort,
    output logic [15:0]        o_pkt_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state_q, state_d;
    logic [LINE_IDX_W-1:0]   line_idx_q, line_idx_d;
    logic                    first_line_q, first_line_d;
    logic                    fs_pend_q, fs_pend_d;
    logic [31:0]             hdr_q, hdr_d;
    logic [31:0]             sum_q, sum_d;
    logic [11:0]             wcnt_q, wcnt_d;
    logic [15:0]             pkt_cnt_q, pkt_cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    abort_q, abort_d;
    logic                    rdy_en_q;

    logic                    beat;
    logic                    fifo_wr, fifo_pop, fifo_flush;
    logic                    fifo_full, fifo_empty;
    logic [31:0]             fifo_dout;
    logic [CW-1:0]           fifo_cnt;

    aurora_tx_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (fifo_flush),
        .i_wr_en   (fifo_wr),
        .i_wr_data (i_pix_data),
        .o_full    (fifo_full),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_dout),
        .o_empty   (fifo_empty),
        .o_count   (fifo_cnt)
    );

    // Input side is held off for the first cycle after reset release.
    assign o_pix_ready = rdy_en_q & ~fifo_full;
    assign fifo_wr     = i_pix_valid & rdy_en_q & ~fifo_full;
    assign ovf_d       = (i_frame_start ? 1'b0 : ovf_q) | (i_pix_valid & rdy_en_q & fifo_full);

    assign beat                = tx.m_axi_tx_tvalid & tx.m_axi_tx_tready;
    assign tx.m_axi_tx_tvalid  = (state_q != ST_IDLE);
    assign tx.m_axi_tx_tlast   = (state_q == ST_TAIL);
    assign tx.m_axi_tx_tkeep   = 4'hF;

    always_comb begin
        tx.m_axi_tx_tdata = '0;
        case (state_q)
            ST_HEAD:    tx.m_axi_tx_tdata = hdr_q;
            ST_PAYLOAD: tx.m_axi_tx_tdata = fifo_dout;
            ST_TAIL:    tx.m_axi_tx_tdata = sum_q;
            default:    tx.m_axi_tx_tdata = '0;
        endcase
    end

    // A frame start seen mid-packet is remembered so the in-flight HEAD/TAIL
    // acceptance does not undo the line_idx/first_line reset it applied.
    always_comb begin
        state_d      = state_q;
        line_idx_d   = i_frame_start ? '0 : line_idx_q;
        first_line_d = i_frame_start ? 1'b1 : first_line_q;
        fs_pend_d    = fs_pend_q | (i_frame_start & (state_q != ST_IDLE));
        hdr_d        = hdr_q;
        sum_d        = sum_q;
        wcnt_d       = wcnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        abort_d      = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;

        if ((state_q != ST_IDLE) && !i_channel_up) begin
            state_d    = ST_IDLE;
            abort_d    = 1'b1;
            fifo_flush = 1'b1;
            fs_pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((32'(fifo_cnt) >= 32'(LINE_WORDS)) && i_channel_up) begin
                        state_d = ST_HEAD;
                        hdr_d   = make_hdr(first_line_d, line_idx_d);
                        sum_d   = '0;
                        wcnt_d  = '0;
                    end
                end
                ST_HEAD: begin
                    if (beat) begin
                        state_d = ST_PAYLOAD;
                        if (!(fs_pend_q || i_frame_start)) begin
                            first_line_d = 1'b0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (beat && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        sum_d    = sum_q + fifo_dout;
                        wcnt_d   = wcnt_q + 12'd1;
                        if (wcnt_q == 12'(LINE_WORDS - 1)) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (beat) begin
                        state_d    = ST_IDLE;
                        pkt_cnt_d  = pkt_cnt_q + 16'd1;
                        line_idx_d = (fs_pend_q || i_frame_start) ? '0
                                                                  : line_idx_q + LINE_IDX_W'(1);
                        fs_pend_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            line_idx_q   <= '0;
            first_line_q <= 1'b1;
            fs_pend_q    <= 1'b0;
            hdr_q        <= '0;
            sum_q        <= '0;
            wcnt_q       <= '0;
            pkt_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            abort_q      <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_idx_q   <= line_idx_d;
            first_line_q <= first_line_d;
            fs_pend_q    <= fs_pend_d;
            hdr_q        <= hdr_d;
            sum_q        <= sum_d;
            wcnt_q       <= wcnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            ovf_q        <= ovf_d;
            abort_q      <= abort_d;
            rdy_en_q     <= 1'b1;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_pkt_abort = abort_q;
    assign o_pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Randomized bench for aurora_tx_framer against a line-packet reference model.
module tb_aurora_tx_framer;
    localparam int LW = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_frame_start = 1'b0;
    logic [31:0] i_pix_data = '0;
    logic        i_pix_valid = 1'b0;
    logic        i_channel_up = 1'b0;
    logic        o_pix_ready, o_overflow, o_pkt_abort;
    logic [15:0] o_pkt_cnt;

    aurora_tx_framer_if tx();

    aurora_tx_framer #(.LINE_WORDS(LW), .FIFO_DEPTH(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_pix_data    (i_pix_data),
        .i_pix_valid   (i_pix_valid),
        .o_pix_ready   (o_pix_ready),
        .i_channel_up  (i_channel_up),
        .tx            (tx),
        .o_overflow    (o_overflow),
        .o_pkt_abort   (o_pkt_abort),
        .o_pkt_cnt     (o_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: accepted words, expected beats, line bookkeeping.
    logic [31:0] mq[$];
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    logic [31:0] got[$];
    logic [11:0] m_line = '0;
    bit          m_first = 1'b1;
    int          m_pkts = 0;

    task automatic build_pkts();
        logic [31:0] s;
        logic [31:0] w;
        while (mq.size() >= LW) begin
            exp_d.push_back({16'hA55A, m_first, 3'b000, m_line});
            exp_l.push_back(1'b0);
            s = '0;
            for (int i = 0; i < LW; i++) begin
                w = mq.pop_front();
                s = s + w;
                exp_d.push_back(w);
                exp_l.push_back(1'b0);
            end
            exp_d.push_back(s);
            exp_l.push_back(1'b1);
            m_first = 1'b0;
            m_line  = m_line + 12'd1;
            m_pkts++;
        end
    endtask

    // Sink: random or forced tready, updated just after each rising edge.
    bit stall_en = 1'b0;
    bit ready_force = 1'b1;
    initial begin
        tx.m_axi_tx_tready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            tx.m_axi_tx_tready = stall_en ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    // Monitor on the falling edge: a beat is valid&ready before the next rising edge.
    bit          mon_en = 1'b1;
    int          beats_seen = 0;
    bit          stalled = 1'b0;
    logic [31:0] held_d;
    logic        held_l;
    initial begin
        forever begin
            @(negedge i_clk);
            if (tx.m_axi_tx_tvalid === 1'b1 && tx.m_axi_tx_tready === 1'b1) beats_seen++;
            if (!mon_en || !i_rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 32'(tx.m_axi_tx_tvalid), 32'd1);
                    chk("hold_data", tx.m_axi_tx_tdata, held_d);
                    chk("hold_last", 32'(tx.m_axi_tx_tlast), 32'(held_l));
                end
                if (tx.m_axi_tx_tvalid === 1'b1 && tx.m_axi_tx_tready === 1'b1) begin
                    got.push_back(tx.m_axi_tx_tdata);
                    chk("tkeep", 32'(tx.m_axi_tx_tkeep), 32'hF);
                    if (exp_d.size() == 0) begin
                        chk("unexpected_beat", tx.m_axi_tx_tdata, 32'hFFFF_FFFF);
                    end else begin
                        chk("beat_data", tx.m_axi_tx_tdata, exp_d.pop_front());
                        chk("beat_last", 32'(tx.m_axi_tx_tlast), 32'(exp_l.pop_front()));
                    end
                end
                stalled = (tx.m_axi_tx_tvalid === 1'b1) && (tx.m_axi_tx_tready !== 1'b1);
                held_d  = tx.m_axi_tx_tdata;
                held_l  = tx.m_axi_tx_tlast;
            end
        end
    end

    task automatic push_word(input logic [31:0] w, output bit acc);
        i_pix_valid = 1'b1;
        i_pix_data  = w;
        @(negedge i_clk);
        acc = o_pix_ready;
        @(posedge i_clk);
        #1;
        i_pix_valid = 1'b0;
        if (acc) mq.push_back(w);
    endtask

    task automatic feed_pkts(input int n, input bit gaps);
        int target;
        bit acc;
        target = m_pkts + n;
        while (m_pkts < target) begin
            push_word($urandom, acc);
            build_pkts();
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        end
    endtask

    task automatic pulse_fs();
        i_frame_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_frame_start = 1'b0;
        m_line  = '0;
        m_first = 1'b1;
    endtask

    task automatic wait_pkts(input int n);
        int k;
        k = 0;
        while (o_pkt_cnt != 16'(n) && k < 2000) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        chk("pkt_cnt", 32'(o_pkt_cnt), 32'(n));
        chk("exp_drained", 32'(exp_d.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [31:0] ref_line0 [6];
    bit          acc;
    int          acc_cnt;
    int          base;
    int          k;
    int          vld_cnt;
    int          abort_cnt;

    initial begin
        ref_line0 = '{32'hA55A8000, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0000000A};

        // Reset values, then pix_ready one cycle after release.
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_tvalid", 32'(tx.m_axi_tx_tvalid), 32'd0);
        chk("rst_tlast", 32'(tx.m_axi_tx_tlast), 32'd0);
        chk("rst_tdata", tx.m_axi_tx_tdata, 32'd0);
        chk("rst_tkeep", 32'(tx.m_axi_tx_tkeep), 32'hF);
        chk("rst_pix_ready", 32'(o_pix_ready), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_abort", 32'(o_pkt_abort), 32'd0);
        chk("rst_pkt_cnt", 32'(o_pkt_cnt), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("pix_ready_at_release", 32'(o_pix_ready), 32'd0);
        @(posedge i_clk);
        #1;
        chk("pix_ready_after_release", 32'(o_pix_ready), 32'd1);

        // First line 1..4 after a frame start.
        i_channel_up = 1'b1;
        pulse_fs();
        got.delete();
        for (int i = 1; i <= 4; i++) begin
            push_word(32'(i), acc);
            build_pkts();
        end
        wait_pkts(m_pkts);
        for (int i = 0; i < 6; i++) chk("line0_beat", got[i], ref_line0[i]);

        // Second line 5..8.
        got.delete();
        for (int i = 5; i <= 8; i++) begin
            push_word(32'(i), acc);
            build_pkts();
        end
        wait_pkts(m_pkts);
        chk("line1_hdr", got[0], 32'hA55A0001);
        chk("line1_tail", got[5], 32'h0000001A);

        // Random words under random tready stalls.
        stall_en = 1'b1;
        feed_pkts(3, 1'b1);
        wait_pkts(m_pkts);
        stall_en = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end

        // Overflow: fill 8-deep buffer with the channel down and tready low.
        pulse_fs();
        chk("overflow_clear_before", 32'(o_overflow), 32'd0);
        i_channel_up = 1'b0;
        ready_force  = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            push_word(32'(100 + i), acc);
            if (acc) acc_cnt++;
        end
        chk("ovf_accepted", 32'(acc_cnt), 32'd8);
        chk("ovf_pix_ready", 32'(o_pix_ready), 32'd0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        pulse_fs();
        chk("ovf_cleared_by_fs", 32'(o_overflow), 32'd0);
        build_pkts();
        ready_force  = 1'b1;
        i_channel_up = 1'b1;
        wait_pkts(m_pkts);

        // Abort: drop channel_up right after payload beat 2 is accepted.
        mon_en = 1'b0;
        base = beats_seen;
        for (int i = 0; i < 4; i++) push_word(32'h1000 + 32'(i), acc);
        k = 0;
        while (beats_seen < base + 3 && k < 200) begin @(posedge i_clk); k++; end
        chk("abort_reach_beat2", 32'(beats_seen - base), 32'd3);
        #1;
        i_channel_up = 1'b0;
        @(posedge i_clk);
        #1;
        chk("abort_tvalid_low", 32'(tx.m_axi_tx_tvalid), 32'd0);
        abort_cnt = int'(o_pkt_abort);
        repeat (4) begin
            @(posedge i_clk);
            #1;
            abort_cnt += int'(o_pkt_abort);
        end
        chk("abort_pulses", 32'(abort_cnt), 32'd1);
        chk("abort_pkt_cnt", 32'(o_pkt_cnt), 32'(m_pkts));
        mq.delete();
        i_channel_up = 1'b1;
        vld_cnt = 0;
        repeat (10) begin
            @(posedge i_clk);
            #1;
            vld_cnt += int'(tx.m_axi_tx_tvalid);
        end
        chk("abort_fifo_flushed", 32'(vld_cnt), 32'd0);
        mon_en = 1'b1;

        // Next line keeps the pre-abort index; frame start lands on its TAIL acceptance.
        got.delete();
        feed_pkts(1, 1'b0);
        k = 0;
        while (!(tx.m_axi_tx_tvalid && tx.m_axi_tx_tlast && tx.m_axi_tx_tready) && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("tail_seen", 32'(k < 200), 32'd1);
        i_frame_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_frame_start = 1'b0;
        m_line  = '0;
        m_first = 1'b1;
        wait_pkts(m_pkts);
        chk("post_abort_hdr", got[0], 32'hA55A0002);
        got.delete();
        feed_pkts(1, 1'b0);
        wait_pkts(m_pkts);
        chk("hdr_after_fs_on_tail", got[0], 32'hA55A8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
